// File: rtl/key_reader.sv
// key_reader: challenge/response sequencer for a serial key device.
// Optional comparator enabled by defining KEY_READER_CMP_EN.
module key_reader #(
  parameter int NBITS = 16,
  parameter int STROBE_CYC = 2,
  parameter logic [NBITS-1:0] EXPECT = NBITS'(16'hA5C3)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      chal,
  input  logic             sdrd,
  output logic             sser_n,
  output logic             ba13,
  output logic             ba12,
  output logic [3:0]       ba_nib,
  output logic             br_w,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] resp,
  output logic             match
);

  localparam int NSTEP = NBITS + 4;
  localparam int SW = $clog2(NSTEP + 1);
  localparam int CW = $clog2(STROBE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, FINISH
  } state_t;

  state_t state, state_n;
  logic [SW-1:0] step;
  logic [CW-1:0] cnt;
  logic [15:0] chal_q;
  logic [NBITS-1:0] resp_q;
  logic load_step, strobe_last, step_last;

  assign load_step = step < SW'(4);
  assign strobe_last = cnt == CW'(STROBE_CYC - 1);
  assign step_last = step == SW'(NSTEP - 1);

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // Next-state sequencing through SETUP/STROBE/HOLD per step.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = SETUP;
      SETUP:  state_n = STROBE;
      STROBE: if (strobe_last) state_n = HOLD;
      HOLD:   state_n = step_last ? FINISH : SETUP;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Step/strobe counters, challenge capture and response shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step   <= '0;
      cnt    <= '0;
      chal_q <= '0;
      resp_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          chal_q <= chal;
          step   <= '0;
          cnt    <= '0;
          resp_q <= '0;
        end
        SETUP: cnt <= '0;
        STROBE: begin
          cnt <= cnt + CW'(1);
          if (strobe_last && !load_step)
            resp_q <= {resp_q[NBITS-2:0], sdrd};
        end
        HOLD: step <= step + SW'(1);
        default: ;
      endcase
    end
  end

`ifdef KEY_READER_CMP_EN
  logic match_q;

  // Compare once the last bit is in; held until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b0;
    else if (state == IDLE && start) match_q <= 1'b0;
    else if (state == HOLD && step_last)
      match_q <= resp_q == EXPECT;
  end

  assign match = match_q;
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
  assign match = 1'b0;
`endif

  // Bus drive: key is addressed only while a step is active.
  always_comb begin
    sser_n = 1'b1;
    ba13   = 1'b1;
    ba12   = 1'b0;
    ba_nib = 4'h0;
    br_w   = 1'b1;
    unique case (state)
      SETUP, STROBE, HOLD: begin
        ba13 = 1'b0;
        ba12 = 1'b1;
        if (load_step)
          ba_nib = chal_q[{step[1:0], 2'b00} +: 4];
        sser_n = state != STROBE;
      end
      default: ;
    endcase
  end

  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign resp = resp_q;

endmodule

// File: tb/tb_key_reader.sv
// tb_key_reader: directed checks of key_reader sequencing.
// Key model serves pat MSB-first on read strobes.
module tb_key_reader;

  logic clk = 0;
  logic rst_n = 1;
  logic start = 0;
  logic [15:0] chal = 0;
  logic sdrd;
  logic sser_n, ba13, ba12, br_w;
  logic busy, done, match;
  logic [3:0] ba_nib;
  logic [15:0] resp;

  key_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .chal(chal), .sdrd(sdrd), .sser_n(sser_n),
    .ba13(ba13), .ba12(ba12), .ba_nib(ba_nib),
    .br_w(br_w), .busy(busy), .done(done),
    .resp(resp), .match(match)
  );

  always #5 clk = ~clk;

`ifdef KEY_READER_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  int pass_cnt = 0;
  int total = 0;

  logic [15:0] pat = 0;
  int npulse = 0;
  int lowcnt = 0;
  int widths[$];
  logic [3:0] nibs[$];
  bit addr_bad = 0;

  int lat;
  logic busy1, done_after, busy_after;

  // Key model: bit for read strobe k is pat[15-k].
  always_comb begin
    int idx;
    idx = 19 - npulse;
    sdrd = 1'b0;
    if (npulse >= 4 && npulse < 20)
      sdrd = pat[idx[3:0]];
  end

  // Strobe monitor: widths, address per pulse.
  always @(negedge clk) begin
    if (!sser_n) begin
      if (lowcnt == 0) nibs.push_back(ba_nib);
      else if (ba_nib !== nibs[$]) addr_bad = 1;
      if (ba13 !== 0 || ba12 !== 1 || br_w !== 1)
        addr_bad = 1;
      lowcnt++;
    end else if (lowcnt > 0) begin
      widths.push_back(lowcnt);
      lowcnt = 0;
      npulse++;
    end
  end

  task automatic clear_mon();
    npulse = 0;
    lowcnt = 0;
    widths.delete();
    nibs.delete();
    addr_bad = 0;
  endtask

  // Start cycle is cycle 1; lat is the cycle done is seen.
  task automatic run_seq(input logic [15:0] c,
                         input logic [15:0] p,
                         input int again);
    int cyc;
    @(negedge clk);
    clear_mon();
    pat = p;
    chal = c;
    start = 1;
    cyc = 1;
    lat = -1;
    busy1 = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = (cyc == again);
      if (cyc == 2) busy1 = busy;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    @(negedge clk);
    start = 0;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    int bad;
    #2 rst_n = 0;
    #1;
    total++;
    if ({sser_n, ba13, ba12, ba_nib, br_w} !== 8'b1100_0001)
      $display("FAIL rst_bus got %b want 11000001",
               {sser_n, ba13, ba12, ba_nib, br_w});
    else pass_cnt++;
    total++;
    if ({busy, done, match} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
               {busy, done, match});
    else pass_cnt++;
    total++;
    if (resp !== 16'h0)
      $display("FAIL rst_resp got %h want 0000", resp);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sser_n !== 1 || busy !== 0 || done !== 0)
        bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL idle_quiet bad cycles %0d want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_main();
    logic [3:0] en;
    run_seq(16'h4321, 16'hA5C3, 0);
    total++;
    if (lat !== 82) $display("FAIL main_lat got %0d want 82", lat);
    else pass_cnt++;
    total++;
    if (busy1 !== 1) $display("FAIL main_busy1 got %b want 1", busy1);
    else pass_cnt++;
    total++;
    if (done_after !== 0 || busy_after !== 0)
      $display("FAIL main_post got done=%b busy=%b want 0 0",
               done_after, busy_after);
    else pass_cnt++;
    total++;
    if (widths.size() !== 20)
      $display("FAIL main_npulse got %0d want 20", widths.size());
    else pass_cnt++;
    for (int i = 0; i < widths.size() && i < 20; i++) begin
      total++;
      if (widths[i] !== 2)
        $display("FAIL width[%0d] got %0d want 2", i, widths[i]);
      else pass_cnt++;
      en = (i < 4) ? 4'(i + 1) : 4'h0;
      total++;
      if (nibs[i] !== en)
        $display("FAIL nib[%0d] got %h want %h", i, nibs[i], en);
      else pass_cnt++;
    end
    total++;
    if (addr_bad !== 0) $display("FAIL main_addr got bad=%b want 0", addr_bad);
    else pass_cnt++;
    total++;
    if (resp !== 16'hA5C3) $display("FAIL main_resp got %h want a5c3", resp);
    else pass_cnt++;
    total++;
    if (match !== CMP) $display("FAIL main_match got %b want %b", match, CMP);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total++;
    if (resp !== 16'hA5C3 || match !== CMP)
      $display("FAIL main_hold got %h/%b want a5c3/%b", resp, match, CMP);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    run_seq(16'hF0A5, 16'h0000, 0);
    total++;
    if (lat !== 82) $display("FAIL zero_lat got %0d want 82", lat);
    else pass_cnt++;
    total++;
    if (resp !== 16'h0000) $display("FAIL zero_resp got %h want 0000", resp);
    else pass_cnt++;
    total++;
    if (match !== 0) $display("FAIL zero_match got %b want 0", match);
    else pass_cnt++;
    total++;
    if (nibs.size() < 4 || {nibs[0], nibs[1], nibs[2], nibs[3]} !== 16'h5A0F)
      $display("FAIL zero_nibs size %0d want 5 a 0 f", nibs.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_seq(16'h1234, 16'h3C5A, 31);
    total++;
    if (lat !== 82) $display("FAIL restart_lat got %0d want 82", lat);
    else pass_cnt++;
    total++;
    if (widths.size() !== 20)
      $display("FAIL restart_npulse got %0d want 20", widths.size());
    else pass_cnt++;
    total++;
    if (resp !== 16'h3C5A) $display("FAIL restart_resp got %h want 3c5a", resp);
    else pass_cnt++;
    run_seq(16'h4321, 16'hA5C3, 82);
    total++;
    if (lat !== 82) $display("FAIL fin_lat got %0d want 82", lat);
    else pass_cnt++;
    total++;
    if (busy_after !== 0)
      $display("FAIL fin_start got busy=%b want 0", busy_after);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    @(negedge clk);
    clear_mon();
    pat = 16'hFFFF;
    chal = 16'h4321;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (n < 300 && !(npulse == 10 && !sser_n)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) $display("FAIL mid_reach timeout got %0d want <300", n);
    else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total++;
    if (sser_n !== 1 || busy !== 0 || ba13 !== 1)
      $display("FAIL mid_async got sser_n=%b busy=%b ba13=%b want 1 0 1",
               sser_n, busy, ba13);
    else pass_cnt++;
    total++;
    if (resp !== 16'h0) $display("FAIL mid_resp got %h want 0000", resp);
    else pass_cnt++;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    total++;
    if (seen !== 0) $display("FAIL mid_nodone got done seen=%b want 0", seen);
    else pass_cnt++;
    run_seq(16'h4321, 16'h5AA5, 0);
    total++;
    if (lat !== 82) $display("FAIL mid_lat got %0d want 82", lat);
    else pass_cnt++;
    total++;
    if (widths.size() !== 20 || nibs[0] !== 4'h1)
      $display("FAIL mid_seq got n=%0d nib0=%h want 20 1",
               widths.size(), nibs[0]);
    else pass_cnt++;
    total++;
    if (resp !== 16'h5AA5) $display("FAIL mid_full got %h want 5aa5", resp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_main();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
